// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU: operation encoding and datapath widths.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;

    // Operation select encoding; all 16 codes are defined operations.
    typedef enum logic [SEL_W-1:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_DIV  = 4'h3,
        OP_SHL  = 4'h4,
        OP_SHR  = 4'h5,
        OP_ROTL = 4'h6,
        OP_ROTR = 4'h7,
        OP_AND  = 4'h8,
        OP_OR   = 4'h9,
        OP_XOR  = 4'hA,
        OP_NOR  = 4'hB,
        OP_NAND = 4'hC,
        OP_XNOR = 4'hD,
        OP_GT   = 4'hE,
        OP_EQ   = 4'hF
    } alu_op_e;

endpackage : alu_pkg

// File: rtl/alu_comb.sv
// Purely combinational ALU decode: produces the next result and carry flag
// from the operands and the operation select.
module alu_comb
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [SEL_W-1:0]  sel_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    logic [DATA_W:0]     sum_w;
    logic [DATA_W:0]     diff_w;
    logic [2*DATA_W-1:0] prod_w;

    // Widened arithmetic so carry, borrow and product overflow are visible.
    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};
    assign prod_w = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

    // Operation decode; carry defaults to 0 and only arithmetic/shift ops set it.
    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        case (alu_op_e'(sel_i))
            OP_ADD: begin
                result_o = sum_w[DATA_W-1:0];
                carry_o  = sum_w[DATA_W];
            end
            OP_SUB: begin
                // Top bit of the 9-bit difference is the borrow (A < B).
                result_o = diff_w[DATA_W-1:0];
                carry_o  = diff_w[DATA_W];
            end
            OP_MUL: begin
                result_o = prod_w[DATA_W-1:0];
                carry_o  = |prod_w[2*DATA_W-1:DATA_W];
            end
            OP_DIV: begin
                // Divide by zero reports all-ones with the carry as error flag.
                if (b_i == '0) begin
                    result_o = {DATA_W{1'b1}};
                    carry_o  = 1'b1;
                end else begin
                    result_o = a_i / b_i;
                end
            end
            OP_SHL: begin
                result_o = {a_i[DATA_W-2:0], 1'b0};
                carry_o  = a_i[DATA_W-1];
            end
            OP_SHR: begin
                result_o = {1'b0, a_i[DATA_W-1:1]};
                carry_o  = a_i[0];
            end
            OP_ROTL: result_o = {a_i[DATA_W-2:0], a_i[DATA_W-1]};
            OP_ROTR: result_o = {a_i[0], a_i[DATA_W-1:1]};
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOR:  result_o = ~(a_i | b_i);
            OP_NAND: result_o = ~(a_i & b_i);
            OP_XNOR: result_o = ~(a_i ^ b_i);
            OP_GT:   result_o = {{(DATA_W-1){1'b0}}, (a_i > b_i)};
            OP_EQ:   result_o = {{(DATA_W-1){1'b0}}, (a_i == b_i)};
            default: begin
                result_o = '0;
                carry_o  = 1'b0;
            end
        endcase
    end

endmodule : alu_comb

// File: rtl/alu_8bit.sv
// 8-bit ALU execute unit: combinational decode followed by a single output
// register stage. One result per cycle, fixed one-cycle latency, no handshake:
// inputs sampled at a rising edge are reflected on the outputs right after it.
module alu_8bit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [SEL_W-1:0]  ALU_Sel,
    output logic [DATA_W-1:0] ALU_Out,
    output logic              CarryOut
);

    logic [DATA_W-1:0] result_d;
    logic              carry_d;
    logic [DATA_W-1:0] result_q;
    logic              carry_q;

    alu_comb u_alu_comb (
        .a_i      (A),
        .b_i      (B),
        .sel_i    (ALU_Sel),
        .result_o (result_d),
        .carry_o  (carry_d)
    );

    // Output register; synchronous reset wins over the operation being sampled.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign ALU_Out  = result_q;
    assign CarryOut = carry_q;

endmodule : alu_8bit

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed vectors with hand-derived
// expectations plus randomized operations checked against an integer model.
module tb_alu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [3:0] ALU_Sel;
    logic [7:0] ALU_Out;
    logic       CarryOut;

    // Expected {CarryOut, ALU_Out} per driven cycle, with a label for reporting.
    logic [8:0] exp_q[$];
    string      name_q[$];

    int checks = 0;
    int errors = 0;

    alu_8bit dut (
        .clk      (clk),
        .rst      (rst),
        .A        (A),
        .B        (B),
        .ALU_Sel  (ALU_Sel),
        .ALU_Out  (ALU_Out),
        .CarryOut (CarryOut)
    );

    // Clock and initial input values.
    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        A       = 8'h00;
        B       = 8'h00;
        ALU_Sel = 4'h0;
        forever #5 clk = ~clk;
    end

    // Reference model from the operation table, using plain integer arithmetic.
    function automatic logic [8:0] model(input int a, input int b, input int sel);
        int r;
        int c;
        r = 0;
        c = 0;
        case (sel)
            0:  begin r = (a + b) % 256; c = ((a + b) > 255) ? 1 : 0; end
            1:  begin r = (a - b + 256) % 256; c = (a < b) ? 1 : 0; end
            2:  begin r = (a * b) % 256; c = ((a * b) > 255) ? 1 : 0; end
            3:  begin
                    if (b == 0) begin r = 255; c = 1; end
                    else r = a / b;
                end
            4:  begin r = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            5:  begin r = a / 2; c = a % 2; end
            6:  r = (a * 2) % 256 + a / 128;
            7:  r = a / 2 + (a % 2) * 128;
            8:  r = a & b;
            9:  r = a | b;
            10: r = a ^ b;
            11: r = 255 - (a | b);
            12: r = 255 - (a & b);
            13: r = 255 - (a ^ b);
            14: r = (a > b) ? 1 : 0;
            15: r = (a == b) ? 1 : 0;
            default: r = 0;
        endcase
        model = {c[0], r[7:0]};
    endfunction

    // Driver: apply one operation for the next edge with an explicit expectation.
    task automatic drive_exp(input logic r, input logic [7:0] a, input logic [7:0] b,
                             input logic [3:0] sel, input logic [7:0] eo,
                             input logic ec, input string nm);
        @(negedge clk);
        rst     = r;
        A       = a;
        B       = b;
        ALU_Sel = sel;
        exp_q.push_back({ec, eo});
        name_q.push_back(nm);
    endtask

    // Driver: apply one operation with the expectation taken from the model.
    task automatic drive_model(input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] sel, input string nm);
        logic [8:0] e;
        e = model(int'(a), int'(b), int'(sel));
        drive_exp(1'b0, a, b, sel, e[7:0], e[8], nm);
    endtask

    // Monitor / scoreboard: after each rising edge, compare against the oldest expectation.
    initial begin
        logic [8:0] e;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if ({CarryOut, ALU_Out} !== e) begin
                    errors++;
                    $display("FAIL %s: got out=%02h carry=%0b, expected out=%02h carry=%0b",
                             nm, ALU_Out, CarryOut, e[7:0], e[8]);
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        logic [7:0] sweep_out[16];
        logic [7:0] ra;
        logic [7:0] rb;
        logic [3:0] rs;
        int         waited;

        sweep_out = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                      8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};

        // Reset held with an operation that would otherwise carry.
        drive_exp(1'b1, 8'hFF, 8'hFF, 4'h0, 8'h00, 1'b0, "reset_hold0");
        drive_exp(1'b1, 8'hFF, 8'hFF, 4'h0, 8'h00, 1'b0, "reset_hold1");
        drive_exp(1'b0, 8'hFF, 8'hFF, 4'h0, 8'hFE, 1'b1, "first_after_reset");

        // Opcode sweep with fixed operands.
        for (int i = 0; i < 16; i++) begin
            drive_exp(1'b0, 8'h0A, 8'h02, 4'(i), sweep_out[i], 1'b0,
                      $sformatf("sweep_op%0h", i));
        end

        // Boundary cases.
        drive_exp(1'b0, 8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1, "add_overflow");
        drive_exp(1'b0, 8'h02, 8'h0A, 4'h1, 8'hF8, 1'b1, "sub_borrow");
        drive_exp(1'b0, 8'h81, 8'h00, 4'h4, 8'h02, 1'b1, "shl_carry");
        drive_exp(1'b0, 8'h81, 8'h00, 4'h5, 8'h40, 1'b1, "shr_carry");
        drive_exp(1'b0, 8'h81, 8'h00, 4'h7, 8'hC0, 1'b0, "rotr");
        drive_exp(1'b0, 8'h81, 8'hFF, 4'h6, 8'h03, 1'b0, "rotl_b_ignored");
        drive_exp(1'b0, 8'h37, 8'h00, 4'h3, 8'hFF, 1'b1, "div_by_zero");
        drive_exp(1'b0, 8'h10, 8'h10, 4'h2, 8'h00, 1'b1, "mul_overflow");
        drive_exp(1'b0, 8'h55, 8'h55, 4'hF, 8'h01, 1'b0, "eq_equal");
        drive_exp(1'b0, 8'h55, 8'h55, 4'hE, 8'h00, 1'b0, "gt_equal");
        drive_exp(1'b0, 8'hC8, 8'h07, 4'h3, 8'h1C, 1'b0, "div_normal");

        // Reset in the middle of traffic, then resume.
        drive_exp(1'b1, 8'hF6, 8'h0A, 4'h0, 8'h00, 1'b0, "reset_mid");
        drive_exp(1'b0, 8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1, "resume_after_reset");
        // Outputs hold with unchanged inputs.
        drive_exp(1'b0, 8'hF6, 8'h0A, 4'h0, 8'h00, 1'b1, "hold_same_inputs");

        // Randomized operations, with corner operand values mixed in.
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: rb = 8'h00;
                1: ra = 8'hFF;
                2: rb = ra;
                default: ;
            endcase
            drive_model(ra, rb, rs, $sformatf("rand%0d_op%0h", i, rs));
        end

        // Drain the scoreboard within a bounded number of cycles.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_alu_8bit
